// File: rtl/trg_sci_frame_rd.sv
// rtl/trg_sci_frame_rd.sv - trigger sci-data frame reader: sync hunt, frame validation, byte forwarding
module trg_sci_frame_rd #(
  parameter int          FRAME_LEN = 32,
  parameter logic [15:0] SYNC_WORD = 16'hEB90
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [7:0]  fifo_data_in,
  input  logic        fifo_empty_in,
  output logic        fifo_rd_out,
  output logic [7:0]  byte_out,
  output logic        byte_valid_out,
  input  logic        byte_ready_in,
  output logic        sof_out,
  output logic        eof_out,
  output logic        frame_good_out,
  output logic        frame_bad_out,
  output logic        seq_gap_out,
  output logic [15:0] good_cnt_out,
  output logic [15:0] bad_cnt_out
);

  localparam int              IW      = $clog2(FRAME_LEN);
  localparam logic [IW-1:0]   LAST    = IW'(FRAME_LEN - 1);
  localparam logic [IW-1:0]   LAST_M1 = IW'(FRAME_LEN - 2);
  localparam logic [IW:0]     LAST_W  = (IW+1)'(FRAME_LEN - 1);

  localparam logic [2:0] HUNT    = 3'd0;
  localparam logic [2:0] SYNC    = 3'd1;
  localparam logic [2:0] COLLECT = 3'd2;
  localparam logic [2:0] CHECK   = 3'd3;
  localparam logic [2:0] SEND    = 3'd4;

  logic [2:0]    state, nstate;
  logic          cap;            // fifo_data_in carries the byte of last cycle's read
  logic [IW-1:0] cidx;           // buffer slot of the next captured byte
  logic [IW-1:0] oidx;           // buffer slot currently on byte_out
  logic [IW:0]   ridx, ridx_n;   // next byte index to request while collecting
  logic [15:0]   sum;
  logic [15:0]   last_cnt;
  logic          have_last;
  logic          rd_n;
  logic          frame_ok;
  logic          seq_gap;
  logic [15:0]   cnt_w, len_w;
  logic [7:0]    frame [FRAME_LEN];

  assign cnt_w    = {frame[2], frame[3]};
  assign len_w    = {frame[4], frame[5]};
  // Evaluated while the final byte is on the bus so the verdict is registered into CHECK.
  assign frame_ok = (sum == {frame[LAST_M1], fifo_data_in}) && (len_w == 16'(FRAME_LEN));
  assign seq_gap  = have_last && (cnt_w != last_cnt + 16'd1);

  // Next state, and whether a new FIFO read may be launched into that state.
  always_comb begin
    nstate = state;
    ridx_n = ridx;
    case (state)
      HUNT: if (cap && fifo_data_in == SYNC_WORD[15:8]) nstate = SYNC;
      SYNC: if (cap) begin
        if (fifo_data_in == SYNC_WORD[7:0]) begin
          nstate = COLLECT;
          ridx_n = (IW+1)'(2);
        end else if (fifo_data_in != SYNC_WORD[15:8]) begin
          nstate = HUNT;
        end
      end
      COLLECT: if (cap && cidx == LAST) nstate = CHECK;
      CHECK:   nstate = frame_good_out ? SEND : HUNT;
      SEND:    if (byte_valid_out && byte_ready_in && oidx == LAST) nstate = HUNT;
      default: nstate = HUNT;
    endcase
    rd_n = !fifo_rd_out && !fifo_empty_in &&
           (nstate == HUNT || nstate == SYNC || (nstate == COLLECT && ridx_n <= LAST_W));
  end

  // Control path: state, read handshake, checksum, verdict, counters and output stream.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= HUNT;
      fifo_rd_out    <= 1'b0;
      cap            <= 1'b0;
      cidx           <= '0;
      oidx           <= '0;
      ridx           <= '0;
      sum            <= '0;
      last_cnt       <= '0;
      have_last      <= 1'b0;
      byte_out       <= 8'h00;
      byte_valid_out <= 1'b0;
      sof_out        <= 1'b0;
      eof_out        <= 1'b0;
      frame_good_out <= 1'b0;
      frame_bad_out  <= 1'b0;
      seq_gap_out    <= 1'b0;
      good_cnt_out   <= '0;
      bad_cnt_out    <= '0;
    end else begin
      state          <= nstate;
      fifo_rd_out    <= rd_n;
      cap            <= fifo_rd_out;
      ridx           <= (rd_n && nstate == COLLECT) ? ridx_n + 1'b1 : ridx_n;
      frame_good_out <= 1'b0;
      frame_bad_out  <= 1'b0;
      seq_gap_out    <= 1'b0;

      if (state == SYNC && cap && fifo_data_in == SYNC_WORD[7:0]) begin
        cidx <= IW'(2);
        sum  <= SYNC_WORD;
      end

      if (state == COLLECT && cap) begin
        cidx <= cidx + 1'b1;
        // Odd slots complete a word; the last word is the checksum itself.
        if (cidx[0] && cidx < LAST_M1) sum <= sum + {frame[cidx - 1'b1], fifo_data_in};
        if (cidx == LAST) begin
          frame_good_out <= frame_ok;
          frame_bad_out  <= !frame_ok;
          if (frame_ok) begin
            seq_gap_out  <= seq_gap;
            last_cnt     <= cnt_w;
            have_last    <= 1'b1;
            if (good_cnt_out != 16'hFFFF) good_cnt_out <= good_cnt_out + 16'd1;
          end else if (bad_cnt_out != 16'hFFFF) begin
            bad_cnt_out  <= bad_cnt_out + 16'd1;
          end
        end
      end

      if (state == CHECK && frame_good_out) begin
        byte_valid_out <= 1'b1;
        byte_out       <= frame[0];
        sof_out        <= 1'b1;
        eof_out        <= 1'b0;
        oidx           <= '0;
      end

      if (state == SEND && byte_valid_out && byte_ready_in) begin
        if (oidx == LAST) begin
          byte_valid_out <= 1'b0;
          sof_out        <= 1'b0;
          eof_out        <= 1'b0;
        end else begin
          oidx     <= oidx + 1'b1;
          byte_out <= frame[oidx + 1'b1];
          sof_out  <= 1'b0;
          eof_out  <= (oidx + 1'b1 == LAST);
        end
      end
    end
  end

  // Frame buffer: written only by captured read data, so it needs no reset.
  always_ff @(posedge clk_in) begin
    if (cap) begin
      case (state)
        HUNT: if (fifo_data_in == SYNC_WORD[15:8]) frame[0] <= fifo_data_in;
        SYNC: begin
          if (fifo_data_in == SYNC_WORD[15:8]) frame[0] <= fifo_data_in;
          else if (fifo_data_in == SYNC_WORD[7:0]) frame[1] <= fifo_data_in;
        end
        COLLECT: frame[cidx] <= fifo_data_in;
        default: ;
      endcase
    end
  end

endmodule
